// File: rtl/ks_multiword_adder.sv
// ks_multiword_adder: streams WORDS x 16-bit operand pairs, LSW first, through
// two chained 16-bit Kogge-Stone adders. The inter-word carry is held in a
// register between beats. One registered sum word is produced per beat, and
// the final carry-out is attached to the most-significant word.

// 16-bit Kogge-Stone parallel-prefix adder.
// The carry-in is folded into the bit-0 generate term, so the prefix tree
// produces every carry, including the carry-out, directly.
module KS_adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    // Level-0 generate/propagate terms, plus the group terms after each prefix level.
    // Propagate vectors only keep the bits that a later level actually reads.
    logic [15:0] w_p0;
    logic [15:0] w_g0;
    logic [15:0] w_g1;
    logic [15:2] w_p1;
    logic [15:0] w_g2;
    logic [15:4] w_p2;
    logic [15:0] w_g3;
    logic [15:8] w_p3;
    logic [15:0] w_g4;
    logic [16:0] w_c;

    assign w_p0   = i_a ^ i_b;
    assign w_c[0] = i_cin;
    assign o_cout = w_c[16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            // Bit-level generate. Bit 0 absorbs the carry-in.
            if (gi == 0) begin : g_lvl0_cin
                assign w_g0[gi] = (i_a[gi] & i_b[gi]) | (w_p0[gi] & i_cin);
            end else begin : g_lvl0
                assign w_g0[gi] = i_a[gi] & i_b[gi];
            end

            // Prefix level 1, span 1.
            if (gi >= 1) begin : g_lvl1_op
                assign w_g1[gi] = w_g0[gi] | (w_p0[gi] & w_g0[gi-1]);
            end else begin : g_lvl1_pass
                assign w_g1[gi] = w_g0[gi];
            end
            if (gi >= 2) begin : g_lvl1_p
                assign w_p1[gi] = w_p0[gi] & w_p0[gi-1];
            end

            // Prefix level 2, span 2.
            if (gi >= 2) begin : g_lvl2_op
                assign w_g2[gi] = w_g1[gi] | (w_p1[gi] & w_g1[gi-2]);
            end else begin : g_lvl2_pass
                assign w_g2[gi] = w_g1[gi];
            end
            if (gi >= 4) begin : g_lvl2_p
                assign w_p2[gi] = w_p1[gi] & w_p1[gi-2];
            end

            // Prefix level 3, span 4.
            if (gi >= 4) begin : g_lvl3_op
                assign w_g3[gi] = w_g2[gi] | (w_p2[gi] & w_g2[gi-4]);
            end else begin : g_lvl3_pass
                assign w_g3[gi] = w_g2[gi];
            end
            if (gi >= 8) begin : g_lvl3_p
                assign w_p3[gi] = w_p2[gi] & w_p2[gi-4];
            end

            // Prefix level 4, span 8. Group propagate is no longer needed.
            if (gi >= 8) begin : g_lvl4_op
                assign w_g4[gi] = w_g3[gi] | (w_p3[gi] & w_g3[gi-8]);
            end else begin : g_lvl4_pass
                assign w_g4[gi] = w_g3[gi];
            end

            // The carry into bit gi+1 is the full-prefix generate of bits gi..0.
            assign w_c[gi+1] = w_g4[gi];
            assign o_sum[gi] = w_p0[gi] ^ w_c[gi];
        end
    endgenerate

endmodule

module ks_multiword_adder #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout
);

    localparam int               CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    // State registers
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic [15:0]      r_out_sum;
    logic             r_out_last;
    logic             r_out_cout;
    logic             r_out_valid;

    // Datapath and handshake wires
    logic [16:0] w_t;
    logic [16:0] w_u;
    logic        w_cin;
    logic        w_word_carry;
    logic        w_is_last;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_take_only;

    // The output register may reload whenever it is empty or is being drained
    // this cycle. This creates a combinational path from out_ready to in_ready
    // on purpose, so a stream can run at one word per cycle.
    assign w_in_ready  = ~r_out_valid | out_ready;
    assign w_accept    = in_valid & w_in_ready;
    assign w_take_only = out_ready & r_out_valid & ~w_accept;
    assign w_is_last   = (r_cnt == LAST_IDX);

    // Word 0 of every operation starts with carry-in 0, so carry never leaks
    // from the previous operation even with back-to-back transfers.
    always_comb begin
        w_cin = 1'b0;
        if (r_cnt != '0) begin
            w_cin = r_cy;
        end
    end

    // Stage 1: raw word sum.
    KS_adder_16bit u_stage1 (
        .i_a   (in_a),
        .i_b   (in_b),
        .i_cin (1'b0),
        .o_sum (w_t[15:0]),
        .o_cout(w_t[16])
    );

    // Stage 2: add the inter-word carry.
    KS_adder_16bit u_stage2 (
        .i_a   (w_t[15:0]),
        .i_b   ({15'b0, w_cin}),
        .i_cin (1'b0),
        .o_sum (w_u[15:0]),
        .o_cout(w_u[16])
    );

    // Stage 2 can only carry out when t[15:0] is all ones, and then t[16] is 0.
    // The two carries are therefore exclusive, and an OR merges them.
    assign w_word_carry = w_t[16] | w_u[16];

    // Word sequencing and the output register stage. Reset overrides any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cy        <= 1'b0;
            r_out_sum   <= 16'h0000;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_sum   <= w_u[15:0];
            r_out_last  <= w_is_last;
            r_out_cout  <= w_is_last & w_word_carry;
            r_out_valid <= 1'b1;
            r_cy        <= w_word_carry;
            r_cnt       <= w_is_last ? '0 : r_cnt + CNT_W'(1);
        end else if (w_take_only) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;

endmodule

// File: tb/tb_ks_multiword_adder.sv
// Directed and randomized checks for ks_multiword_adder with WORDS=4.
module tb_ks_multiword_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [17:0] q_exp[$];   // {last, cout, sum}

    ks_multiword_adder #(.WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_cout (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue one 4-word operation. The expected 64-bit sum and carry-out are given by the caller.
    task automatic push_op(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] s, input logic co);
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(a[16*i +: 16]);
            q_b.push_back(b[16*i +: 16]);
            q_exp.push_back({(i == 3), (i == 3) ? co : 1'b0, s[16*i +: 16]});
        end
    endtask

    // One cycle. Inputs are driven just after a negedge. Handshakes are
    // evaluated #1 later, which is well before the next active edge.
    task automatic step(input logic rdy, input logic vld);
        out_ready = rdy;
        in_valid  = vld && (q_a.size() > 0);
        if (in_valid) begin
            in_a = q_a[0];
            in_b = q_b[0];
        end else begin
            in_a = 16'h0;
            in_b = 16'h0;
        end
        #1;
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                check("extra_word", {14'h0, out_last, out_cout, out_sum}, 32'hDEAD_BEEF);
            end else begin
                check("word", {14'h0, out_last, out_cout, out_sum}, {14'h0, q_exp[0]});
                void'(q_exp.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles, input bit gaps);
        int n = 0;
        while ((q_exp.size() > 0 || q_a.size() > 0) && n < max_cycles) begin
            if (gaps) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            else      step(1'b1, 1'b1);
            n++;
        end
        if (q_exp.size() != 0) check("drain_timeout", q_exp.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        logic [64:0] s65;
        logic [63:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_cout",  out_cout,  0);
        check("rst_in_ready",  in_ready,  1);
        @(negedge clk);

        // Full carry ripple
        push_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0, 1'b1);
        drain(100, 1'b0);
        $display("op ripple done checks=%0d", n_checks);

        // No-carry add
        push_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 64'h0011_0022_0033_0044, 1'b0);
        drain(100, 1'b0);
        $display("op nocarry done checks=%0d", n_checks);

        // Backpressure: stall while word 1 (0033) is held in the output register
        push_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 64'h0011_0022_0033_0044, 1'b0);
        n = 0;
        while (q_exp.size() > 3 && n < 20) begin
            step(1'b1, 1'b1);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = q_a[0];
            in_b      = q_b[0];
            #1;
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_sum",  out_sum,   32'h0033);
            @(negedge clk);
        end
        drain(100, 1'b0);
        $display("op backpressure done checks=%0d", n_checks);

        // Carry isolation across back-to-back operations
        push_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        push_op(64'h0, 64'h0, 64'h0, 1'b0);
        drain(100, 1'b0);
        $display("op carry_isolation done checks=%0d", n_checks);

        // Reset mid-operation, with a concurrent valid input
        push_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0, 1'b1);
        n = 0;
        while (q_exp.size() > 2 && n < 20) begin
            step(1'b1, 1'b1);
            n++;
        end
        rst = 1'b1; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0000; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        q_a.delete(); q_b.delete(); q_exp.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum",   out_sum,   0);
        check("midrst_in_ready",  in_ready,  1);
        @(negedge clk);
        push_op(64'h5, 64'h7, 64'h000C, 1'b0);
        drain(100, 1'b0);
        $display("op reset_midop done checks=%0d", n_checks);

        // Random operations with gaps on both sides, checked against a 65-bit sum
        for (int i = 0; i < 200; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (i % 10 == 0) rb = ~ra;   // exercise long carry chains
            if (i % 10 == 1) rb = ~ra + 64'h1;
            s65 = {1'b0, ra} + {1'b0, rb};
            push_op(ra, rb, s65[63:0], s65[64]);
        end
        drain(20000, 1'b1);
        $display("op random done checks=%0d", n_checks);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
